// File: rtl/fixed_divide.sv
//------------------------------------------------------------------------------
// Module   : fixed_divide
// Brief    : Iterative signed fixed-point divider, restoring shift-subtract
//            core producing one quotient bit per clock, with saturation.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fixed_divide #(
    parameter int fractional_size = 12,
    parameter int operand_size    = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [operand_size-1:0] i_a,
    input  logic [operand_size-1:0] i_b,
    output logic                    o_valid,
    output logic [operand_size-1:0] o_res,
    output logic                    o_overflow,
    output logic                    o_div_by_zero
);

    localparam int W  = operand_size;
    localparam int F  = fractional_size;
    localparam int N  = W + F;
    localparam int CW = $clog2(N + 1);

    localparam logic [CW-1:0] c_last_iter = CW'(N - 1);
    localparam logic [N-1:0]  c_pos_limit = N'((longint'(1) << (W - 1)) - 1);
    localparam logic [N-1:0]  c_neg_limit = N'(longint'(1) << (W - 1));
    localparam logic [W-1:0]  c_res_max   = W'((longint'(1) << (W - 1)) - 1);
    localparam logic [W-1:0]  c_res_min   = W'(longint'(1) << (W - 1));

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q,    state_d;
    logic [N-1:0]    dividend_q, dividend_d;
    logic [N-1:0]    quot_q,     quot_d;
    logic [W-1:0]    rem_q,      rem_d;
    logic [W-1:0]    babs_q,     babs_d;
    logic [CW-1:0]   cnt_q,      cnt_d;
    logic            sign_q,     sign_d;
    logic            a_neg_q,    a_neg_d;
    logic [W-1:0]    res_q,      res_d;
    logic            ovf_q,      ovf_d;
    logic            dbz_q,      dbz_d;
    logic            valid_q,    valid_d;

    logic [W-1:0]    w_a_abs;
    logic [W-1:0]    w_b_abs;
    logic [W:0]      w_rem_shift;
    logic [W-1:0]    w_rem_sub;
    logic            w_ge;
    logic [W-1:0]    w_neg_mag;

    // Magnitudes as unsigned W-bit values; the most negative operand maps to 2^(W-1).
    assign w_a_abs     = i_a[W-1] ? (~i_a + W'(1)) : i_a;
    assign w_b_abs     = i_b[W-1] ? (~i_b + W'(1)) : i_b;

    assign w_rem_shift = {rem_q, dividend_q[N-1]};
    assign w_ge        = (w_rem_shift >= {1'b0, babs_q});
    assign w_rem_sub   = W'(w_rem_shift - {1'b0, babs_q});
    assign w_neg_mag   = ~quot_q[W-1:0] + W'(1);

    always_comb begin
        state_d    = state_q;
        dividend_d = dividend_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        babs_d     = babs_q;
        cnt_d      = cnt_q;
        sign_d     = sign_q;
        a_neg_d    = a_neg_q;
        res_d      = res_q;
        ovf_d      = ovf_q;
        dbz_d      = dbz_q;
        valid_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    sign_d     = i_a[W-1] ^ i_b[W-1];
                    a_neg_d    = i_a[W-1];
                    babs_d     = w_b_abs;
                    dividend_d = N'(w_a_abs) << F;
                    quot_d     = '0;
                    rem_d      = '0;
                    cnt_d      = '0;
                    state_d    = S_CALC;
                end
            end

            S_CALC: begin
                // A zero divisor keeps iterating so latency is data-independent.
                rem_d      = w_ge ? w_rem_sub : w_rem_shift[W-1:0];
                quot_d     = {quot_q[N-2:0], w_ge};
                dividend_d = dividend_q << 1;
                cnt_d      = cnt_q + CW'(1);
                if (cnt_q == c_last_iter) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                valid_d = 1'b1;
                state_d = S_IDLE;
                if (babs_q == '0) begin
                    res_d = a_neg_q ? c_res_min : c_res_max;
                    ovf_d = 1'b0;
                    dbz_d = 1'b1;
                end else if (!sign_q) begin
                    dbz_d = 1'b0;
                    if (quot_q > c_pos_limit) begin
                        res_d = c_res_max;
                        ovf_d = 1'b1;
                    end else begin
                        res_d = quot_q[W-1:0];
                        ovf_d = 1'b0;
                    end
                end else begin
                    dbz_d = 1'b0;
                    if (quot_q > c_neg_limit) begin
                        res_d = c_res_min;
                        ovf_d = 1'b1;
                    end else begin
                        res_d = w_neg_mag;
                        ovf_d = 1'b0;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            dividend_q <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            babs_q     <= '0;
            cnt_q      <= '0;
            sign_q     <= 1'b0;
            a_neg_q    <= 1'b0;
            res_q      <= '0;
            ovf_q      <= 1'b0;
            dbz_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            dividend_q <= dividend_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            babs_q     <= babs_d;
            cnt_q      <= cnt_d;
            sign_q     <= sign_d;
            a_neg_q    <= a_neg_d;
            res_q      <= res_d;
            ovf_q      <= ovf_d;
            dbz_q      <= dbz_d;
            valid_q    <= valid_d;
        end
    end

    assign o_ready       = (state_q == S_IDLE);
    assign o_valid       = valid_q;
    assign o_res         = res_q;
    assign o_overflow    = ovf_q;
    assign o_div_by_zero = dbz_q;

endmodule

`default_nettype wire
